pwm_cfg_parser: RTL

Byte-stream command parser upstream of the per-channel PWM controllers. It takes framed configuration commands from the UART receiver one byte per rx_vld strobe. It validates sync, channel range, field width and checksum. On a good frame it emits a single-cycle config broadcast (valid, channel, enable, period, high-level) that all PWM channel controllers share; each controller latches only its own index.

---
 rtl/pwm_cfg_pkg.sv | 24 ++
 rtl/pwm_cfg_timeout.sv | 37 +++
 rtl/pwm_cfg_parser.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg -- shared definitions for the PWM configuration command path.
// Holds the frame constants, rejection codes, parser FSM state type and the
// PWM counter width that the per-channel PWM controllers also use.
package pwm_cfg_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 12;
  localparam int         PWM_CNT_W = 28;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_CHAN    = 2'd2;
  localparam logic [1:0] ERR_RANGE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAN,
    ST_FLAGS,
    ST_PERIOD,
    ST_HLEVEL,
    ST_CSUM
  } cfg_state_t;

endpackage

// File: rtl/pwm_cfg_timeout.sv
// pwm_cfg_timeout -- inter-byte idle timer for the config parser.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : count while a frame is in progress
//   clr       : a byte arrived; restart the idle interval
//   expire    : single-cycle, TIMEOUT_CYCLES-1 cycles after the last clr with
//               no clr since; the parser registers it one cycle later, so the
//               visible error lands TIMEOUT_CYCLES cycles after the last byte
module pwm_cfg_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A byte in the expiry cycle itself suppresses the timeout.
  assign expire = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/pwm_cfg_parser.sv
// pwm_cfg_parser -- byte-stream command parser feeding the PWM channels.
// Frame: A5 | chan | flags(bit0=en) | period[31:0] MSB first |
//        hlevel[31:0] MSB first | xor of bytes 1..10.
// A good frame produces a one-cycle pwm_config_vld broadcast; a bad one a
// one-cycle frame_err with err_code (held until the next error).
// Build option: define PWM_CFG_TIMEOUT_EN to abort a stalled partial frame
// after TIMEOUT_CYCLES idle cycles (reported with err_code 0).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rx_vld, rx_data     : received byte strobe and data
//   pwm_config_vld      : config broadcast valid pulse
//   pwm_config_channel  : target channel index
//   pwm_en              : PWM output enable
//   pwm_period          : period count threshold
//   pwm_hlevel          : high-level count threshold
//   frame_err, err_code : rejection pulse and reason
module pwm_cfg_parser
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_vld,
  input  logic [7:0]           rx_data,
  output logic                 pwm_config_vld,
  output logic [7:0]           pwm_config_channel,
  output logic                 pwm_en,
  output logic [PWM_CNT_W-1:0] pwm_period,
  output logic [PWM_CNT_W-1:0] pwm_hlevel,
  output logic                 frame_err,
  output logic [1:0]           err_code
);

  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_nch
    $error("pwm_cfg_parser: NUM_CHANNELS out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("pwm_cfg_parser: TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [8:0] NUM_CH_W = 9'(NUM_CHANNELS);

  cfg_state_t  state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  chan_q;
  logic        en_q;
  logic [31:0] acc_q;
  logic [31:0] period_q;
  logic [7:0]  csum_q;
  logic        tmo_expire;

  logic        frame_done;
  logic        csum_bad;
  logic        chan_bad;
  logic        range_bad;

`ifdef PWM_CFG_TIMEOUT_EN
  pwm_cfg_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != ST_IDLE),
    .clr    (rx_vld),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_vld) begin
      case (state_q)
        ST_IDLE:   if (rx_data == SYNC_BYTE) state_d = ST_CHAN;
        ST_CHAN:   state_d = ST_FLAGS;
        ST_FLAGS:  state_d = ST_PERIOD;
        ST_PERIOD: if (byte_cnt_q == 2'd3) state_d = ST_HLEVEL;
        ST_HLEVEL: if (byte_cnt_q == 2'd3) state_d = ST_CSUM;
        ST_CSUM:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = ST_IDLE;
    end
  end

  // In CSUM the accumulator holds hlevel; period was captured on its 4th byte.
  assign frame_done = rx_vld && (state_q == ST_CSUM);
  assign csum_bad   = (csum_q != rx_data);
  assign chan_bad   = ({1'b0, chan_q} >= NUM_CH_W);
  assign range_bad  = (period_q[31:28] != 4'd0) || (acc_q[31:28] != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      chan_q     <= '0;
      en_q       <= 1'b0;
      acc_q      <= '0;
      period_q   <= '0;
      csum_q     <= '0;
    end else if (rx_vld) begin
      case (state_q)
        ST_CHAN: begin
          chan_q <= rx_data;
          csum_q <= rx_data;
        end
        ST_FLAGS: begin
          en_q       <= rx_data[0];
          csum_q     <= csum_q ^ rx_data;
          byte_cnt_q <= '0;
        end
        ST_PERIOD, ST_HLEVEL: begin
          acc_q      <= {acc_q[23:0], rx_data};
          csum_q     <= csum_q ^ rx_data;
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (state_q == ST_PERIOD && byte_cnt_q == 2'd3) begin
            period_q <= {acc_q[23:0], rx_data};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_config_vld     <= 1'b0;
      pwm_config_channel <= '0;
      pwm_en             <= 1'b0;
      pwm_period         <= '0;
      pwm_hlevel         <= '0;
      frame_err          <= 1'b0;
      err_code           <= ERR_TIMEOUT;
    end else begin
      pwm_config_vld <= 1'b0;
      frame_err      <= 1'b0;
      if (frame_done) begin
        if (csum_bad) begin
          frame_err <= 1'b1;
          err_code  <= ERR_CSUM;
        end else if (chan_bad) begin
          frame_err <= 1'b1;
          err_code  <= ERR_CHAN;
        end else if (range_bad) begin
          frame_err <= 1'b1;
          err_code  <= ERR_RANGE;
        end else begin
          pwm_config_vld     <= 1'b1;
          pwm_config_channel <= chan_q;
          pwm_en             <= en_q;
          pwm_period         <= period_q[PWM_CNT_W-1:0];
          pwm_hlevel         <= acc_q[PWM_CNT_W-1:0];
        end
      end else if (tmo_expire) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
      end
    end
  end

endmodule
